// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode: IF/ID register, operand forwarding, branch/jump resolution,
// hazard stall and the ID/EX register.
module decode_stage #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PC_SEL_WIDTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [XLEN-1:0]           pc_decode,
    input  logic [XLEN-1:0]           instr_decode,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [XLEN-1:0]           rs1_rdata,
    input  logic [XLEN-1:0]           rs2_rdata,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      mem_reg_write,
    input  logic [XLEN-1:0]           mem_fwd_data,
    output logic [XLEN-1:0]           br_decode,
    output logic [XLEN-1:0]           jal_decode,
    output logic [XLEN-1:0]           jalr_decode,
    output logic [PC_SEL_WIDTH-1:0]   pc_sel,
    output logic                      stall_if,
    output logic                      flush_if,
    output logic [XLEN-1:0]           pc_ex,
    output logic [XLEN-1:0]           rs1_ex,
    output logic [XLEN-1:0]           rs2_ex,
    output logic [XLEN-1:0]           imm_ex,
    output logic [REG_ADDR_WIDTH-1:0] rd_ex,
    output logic [7:0]                ctrl_ex
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [PC_SEL_WIDTH-1:0] SEL_PC4  = PC_SEL_WIDTH'(0);
    localparam logic [PC_SEL_WIDTH-1:0] SEL_BR   = PC_SEL_WIDTH'(1);
    localparam logic [PC_SEL_WIDTH-1:0] SEL_JAL  = PC_SEL_WIDTH'(2);
    localparam logic [PC_SEL_WIDTH-1:0] SEL_JALR = PC_SEL_WIDTH'(3);

    logic [XLEN-1:0]           r_pc, r_instr;
    logic [XLEN-1:0]           r_pc_ex, r_rs1_ex, r_rs2_ex, r_imm_ex;
    logic [REG_ADDR_WIDTH-1:0] r_rd_ex;
    logic [7:0]                r_ctrl_ex;

    logic [6:0]                w_opcode;
    logic [2:0]                w_funct3;
    logic [REG_ADDR_WIDTH-1:0] w_rs1_idx, w_rs2_idx, w_rd_idx;
    logic [XLEN-1:0]           w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
    logic [XLEN-1:0]           w_rs1v, w_rs2v;
    logic                      w_known, w_valid, w_use_rs1, w_use_rs2, w_reg_write;
    logic                      w_mem_read, w_mem_write, w_is_branch, w_is_jal, w_is_jalr;
    logic                      w_taken, w_src_hit, w_stall;
    logic [3:0]                w_alu_op;

    assign w_opcode  = r_instr[6:0];
    assign w_funct3  = r_instr[14:12];
    assign w_rd_idx  = r_instr[7 +: REG_ADDR_WIDTH];
    assign w_rs1_idx = r_instr[15 +: REG_ADDR_WIDTH];
    assign w_rs2_idx = r_instr[20 +: REG_ADDR_WIDTH];
    assign rs1_addr  = w_rs1_idx;
    assign rs2_addr  = w_rs2_idx;

    assign w_imm_i = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b = {{(XLEN-12){r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_imm_u = {r_instr[XLEN-1:12], 12'b0};
    assign w_imm_j = {{(XLEN-20){r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

    // The MEM result is newer than the regfile copy; x0 is hardwired regardless of forwarding.
    assign w_rs1v = (w_rs1_idx == '0) ? '0 :
                    (mem_reg_write && mem_rd == w_rs1_idx) ? mem_fwd_data : rs1_rdata;
    assign w_rs2v = (w_rs2_idx == '0) ? '0 :
                    (mem_reg_write && mem_rd == w_rs2_idx) ? mem_fwd_data : rs2_rdata;

    always_comb begin
        w_known     = 1'b1;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        w_alu_op    = 4'h0;
        w_imm       = w_imm_i;
        case (w_opcode)
            OP_LUI:    begin w_reg_write = 1'b1; w_imm = w_imm_u; w_alu_op = 4'hF; end
            OP_AUIPC:  begin w_reg_write = 1'b1; w_imm = w_imm_u; end
            OP_JAL:    begin w_reg_write = 1'b1; w_is_jal = 1'b1; end
            OP_JALR:   begin w_reg_write = 1'b1; w_is_jalr = 1'b1; w_use_rs1 = 1'b1; end
            OP_BRANCH: begin w_is_branch = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_b; end
            OP_LOAD:   begin w_reg_write = 1'b1; w_mem_read = 1'b1; w_use_rs1 = 1'b1; end
            OP_STORE:  begin
                w_mem_write = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_s;
            end
            OP_IMM:    begin
                w_reg_write = 1'b1; w_use_rs1 = 1'b1;
                w_alu_op    = {(w_funct3 == 3'b101) & r_instr[30], w_funct3};
            end
            OP_REG:    begin
                w_reg_write = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_alu_op    = {r_instr[30], w_funct3};
            end
            default:   w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = (w_rs1v == w_rs2v);
            3'b001:  w_taken = (w_rs1v != w_rs2v);
            3'b100:  w_taken = ($signed(w_rs1v) <  $signed(w_rs2v));
            3'b101:  w_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
            3'b110:  w_taken = (w_rs1v <  w_rs2v);
            3'b111:  w_taken = (w_rs1v >= w_rs2v);
            default: w_taken = 1'b0;
        endcase
    end

    assign br_decode   = r_pc + w_imm_b;
    assign jal_decode  = r_pc + w_imm_j;
    assign jalr_decode = (w_rs1v + w_imm_i) & ~XLEN'(1);

    // Loads stall any consumer; ALU results only stall decode-time consumers (branch, JALR).
    assign w_valid   = (r_instr != '0) && w_known;
    assign w_src_hit = (r_rd_ex != '0) &&
                       ((w_use_rs1 && r_rd_ex == w_rs1_idx) || (w_use_rs2 && r_rd_ex == w_rs2_idx));
    assign w_stall   = w_valid && r_ctrl_ex[7] && w_src_hit &&
                       (r_ctrl_ex[5] || ((w_is_branch || w_is_jalr) && r_ctrl_ex[6]));
    assign stall_if  = w_stall;

    always_comb begin
        pc_sel   = SEL_PC4;
        flush_if = 1'b0;
        if (w_valid && !w_stall) begin
            if (w_is_jal)                      pc_sel = SEL_JAL;
            else if (w_is_jalr)                pc_sel = SEL_JALR;
            else if (w_is_branch && w_taken)   pc_sel = SEL_BR;
            flush_if = (pc_sel != SEL_PC4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_instr <= '0;
        end else if (!w_stall) begin
            r_pc    <= pc_decode;
            r_instr <= flush_if ? '0 : instr_decode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_ex <= '0; r_rs1_ex <= '0; r_rs2_ex <= '0; r_imm_ex <= '0; r_rd_ex <= '0; r_ctrl_ex <= '0;
        end else if (w_stall || !w_valid) begin
            r_pc_ex <= '0; r_rs1_ex <= '0; r_rs2_ex <= '0; r_imm_ex <= '0; r_rd_ex <= '0; r_ctrl_ex <= '0;
        end else begin
            r_pc_ex   <= r_pc;
            r_rs1_ex  <= w_rs1v;
            r_rs2_ex  <= w_rs2v;
            r_imm_ex  <= (w_is_jal || w_is_jalr) ? XLEN'(4) : w_imm;
            r_rd_ex   <= w_reg_write ? w_rd_idx : '0;
            r_ctrl_ex <= {1'b1, w_reg_write, w_mem_read, w_mem_write, w_alu_op};
        end
    end

    assign pc_ex   = r_pc_ex;
    assign rs1_ex  = r_rs1_ex;
    assign rs2_ex  = r_rs2_ex;
    assign imm_ex  = r_imm_ex;
    assign rd_ex   = r_rd_ex;
    assign ctrl_ex = r_ctrl_ex;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed bench for decode_stage with a cycle-level behavioural model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_decode, instr_decode, rs1_rdata, rs2_rdata, mem_fwd_data;
    logic [4:0]  rs1_addr, rs2_addr, mem_rd, rd_ex;
    logic        mem_reg_write, stall_if, flush_if;
    logic [31:0] br_decode, jal_decode, jalr_decode, pc_ex, rs1_ex, rs2_ex, imm_ex;
    logic [1:0]  pc_sel;
    logic [7:0]  ctrl_ex;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_decode(pc_decode), .instr_decode(instr_decode),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_fwd_data(mem_fwd_data),
        .br_decode(br_decode), .jal_decode(jal_decode), .jalr_decode(jalr_decode),
        .pc_sel(pc_sel), .stall_if(stall_if), .flush_if(flush_if),
        .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .imm_ex(imm_ex),
        .rd_ex(rd_ex), .ctrl_ex(ctrl_ex)
    );

    // Stale regfile contents; x0 deliberately holds garbage to prove it reads as zero.
    logic [31:0] regs [32];
    assign rs1_rdata = regs[rs1_addr];
    assign rs2_rdata = regs[rs2_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } ex_t;

    typedef struct {
        logic [4:0]  a1, a2;
        logic [31:0] br, jal, jalr;
        logic [1:0]  sel;
        logic        stall, flush;
        ex_t         nxt;
    } exp_t;

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [4:0] mrd,
                                            input logic mwe, input logic [31:0] mdat);
        if (a == 5'd0) return 32'd0;
        if (mwe && mrd == a) return mdat;
        return regs[a];
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins, input ex_t ex,
                                   input logic [4:0] mrd, input logic mwe, input logic [31:0] mdat);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] v1, v2, i_imm, s_imm, b_imm, u_imm, j_imm;
        bit ld, st, br, jal, jalr, lui, auipc, alu, alui, valid, use1, use2, hit, taken, wr, redirect;
        op = ins[6:0];
        f3 = ins[14:12];
        e.a1 = ins[19:15];
        e.a2 = ins[24:20];
        i_imm = int'($signed(ins[31:20]));
        s_imm = int'($signed({ins[31:25], ins[11:7]}));
        b_imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        u_imm = {ins[31:12], 12'h000};
        j_imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        v1 = operand(e.a1, mrd, mwe, mdat);
        v2 = operand(e.a2, mrd, mwe, mdat);
        ld = (op == 7'h03); st = (op == 7'h23); br = (op == 7'h63); jal = (op == 7'h6F);
        jalr = (op == 7'h67); lui = (op == 7'h37); auipc = (op == 7'h17);
        alu = (op == 7'h33); alui = (op == 7'h13);
        valid = (ins != 32'd0) && (ld || st || br || jal || jalr || lui || auipc || alu || alui);
        use1  = ld || st || br || jalr || alu || alui;
        use2  = st || br || alu;
        wr    = ld || jal || jalr || lui || auipc || alu || alui;
        hit   = (ex.rd != 5'd0) && ((use1 && ex.rd == e.a1) || (use2 && ex.rd == e.a2));
        e.stall = valid && ex.ctrl[7] && hit && (ex.ctrl[5] || ((br || jalr) && ex.ctrl[6]));
        case (f3)
            3'd0: taken = (v1 == v2);
            3'd1: taken = (v1 != v2);
            3'd4: taken = (int'(v1) <  int'(v2));
            3'd5: taken = (int'(v1) >= int'(v2));
            3'd6: taken = ({32'd0, v1} <  {32'd0, v2});
            3'd7: taken = ({32'd0, v1} >= {32'd0, v2});
            default: taken = 1'b0;
        endcase
        redirect = valid && !e.stall && (jal || jalr || (br && taken));
        e.flush = redirect;
        e.sel   = !redirect ? 2'd0 : jal ? 2'd2 : jalr ? 2'd3 : 2'd1;
        e.br    = pc + b_imm;
        e.jal   = pc + j_imm;
        e.jalr  = (v1 + i_imm) & 32'hFFFF_FFFE;
        e.nxt   = '0;
        if (valid && !e.stall) begin
            e.nxt.pc   = pc;
            e.nxt.rs1  = v1;
            e.nxt.rs2  = v2;
            e.nxt.imm  = (jal || jalr) ? 32'd4 : st ? s_imm : br ? b_imm : (lui || auipc) ? u_imm : i_imm;
            e.nxt.rd   = wr ? ins[11:7] : 5'd0;
            e.nxt.ctrl = {1'b1, wr, ld, st,
                          alu ? {ins[30], f3} : alui ? {(f3 == 3'd5) & ins[30], f3} : lui ? 4'hF : 4'h0};
        end
        return e;
    endfunction

    logic [31:0] m_pc, m_instr;
    ex_t         m_ex;

    initial begin : compare
        exp_t e;
        m_pc = 0; m_instr = 0; m_ex = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin m_pc = 0; m_instr = 0; m_ex = '0; end
            e = model(m_pc, m_instr, m_ex, mem_rd, mem_reg_write, mem_fwd_data);
            chk("rs1_addr", 32'(rs1_addr), 32'(e.a1));
            chk("rs2_addr", 32'(rs2_addr), 32'(e.a2));
            chk("br_decode", br_decode, e.br);
            chk("jal_decode", jal_decode, e.jal);
            chk("jalr_decode", jalr_decode, e.jalr);
            chk("pc_sel", 32'(pc_sel), 32'(e.sel));
            chk("stall_if", 32'(stall_if), 32'(e.stall));
            chk("flush_if", 32'(flush_if), 32'(e.flush));
            chk("pc_ex", pc_ex, m_ex.pc);
            chk("rs1_ex", rs1_ex, m_ex.rs1);
            chk("rs2_ex", rs2_ex, m_ex.rs2);
            chk("imm_ex", imm_ex, m_ex.imm);
            chk("rd_ex", 32'(rd_ex), 32'(m_ex.rd));
            chk("ctrl_ex", 32'(ctrl_ex), 32'(m_ex.ctrl));
            @(posedge clk);
            if (!rst_n) begin
                m_pc = 0; m_instr = 0; m_ex = '0;
            end else begin
                m_ex = e.nxt;
                if (!e.stall) begin
                    m_pc    = pc_decode;
                    m_instr = e.flush ? 32'd0 : instr_decode;
                end
            end
        end
    end

    task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] mrd = 5'd0,
                        input logic mwe = 1'b0, input logic [31:0] mdat = 32'd0);
        @(posedge clk);
        #1;
        pc_decode = pc; instr_decode = ins;
        mem_rd = mrd; mem_reg_write = mwe; mem_fwd_data = mdat;
    endtask

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] ADDI_X1  = 32'h0050_0093;
    localparam logic [31:0] LW_X2    = 32'h0000_A103;
    localparam logic [31:0] ADD_X3   = 32'h0021_01B3;
    localparam logic [31:0] BEQ_16   = 32'h0000_0863;
    localparam logic [31:0] JALR_X1  = 32'hFFD2_80E7;
    localparam logic [31:0] ADDI_X4  = 32'h0070_0213;
    localparam logic [31:0] BNE_X4   = 32'h0002_1463;
    localparam logic [31:0] JAL_X1   = 32'h0200_00EF;

    initial begin : stimulus
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 * i + 32'h11;
        regs[0] = 32'hDEAD_BEEF;
        regs[4] = 32'h0;
        regs[5] = 32'h500;
        rst_n = 1'b0;
        pc_decode = 0; instr_decode = 0; mem_rd = 0; mem_reg_write = 0; mem_fwd_data = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADDI x1,x0,5; a forward aimed at x0 must be ignored
        step(32'h10, ADDI_X1);
        step(32'h14, NOP, 5'd0, 1'b1, 32'h999);
        @(negedge clk); chk("addi_no_stall", 32'(stall_if), 32'd0);
        step(32'h18, NOP);
        @(negedge clk);
        chk("addi_rd", 32'(rd_ex), 32'd1);
        chk("addi_imm", imm_ex, 32'd5);
        chk("addi_ctrl", 32'(ctrl_ex), 32'hC0);
        chk("addi_x0_reads_0", rs1_ex, 32'd0);

        // LW x2 then ADD x3,x2,x2: one stall cycle, then load data forwarded from MEM
        step(32'h40, LW_X2);
        step(32'h44, ADD_X3);
        step(32'h48, NOP);
        @(negedge clk);
        chk("lu_stall", 32'(stall_if), 32'd1);
        chk("lu_lw_ctrl", 32'(ctrl_ex), 32'hE0);
        step(32'h48, NOP, 5'd2, 1'b1, 32'h77);
        @(negedge clk);
        chk("lu_released", 32'(stall_if), 32'd0);
        chk("lu_bubble", 32'(ctrl_ex), 32'h00);
        step(32'h4C, NOP);
        @(negedge clk);
        chk("lu_add_rd", 32'(rd_ex), 32'd3);
        chk("lu_add_fwd", rs1_ex, 32'h77);

        // BEQ x0,x0,+16 at 0x20: redirect and flush of the following fetch slot
        step(32'h20, BEQ_16);
        step(32'h24, ADDI_X1);
        @(negedge clk);
        chk("beq_sel", 32'(pc_sel), 32'd1);
        chk("beq_target", br_decode, 32'h30);
        chk("beq_flush", 32'(flush_if), 32'd1);
        step(32'h30, NOP);
        @(negedge clk);
        chk("beq_flushed_slot", 32'(rs2_addr), 32'd0);
        chk("beq_in_ex", 32'(ctrl_ex), 32'h80);
        step(32'h34, NOP);

        // JALR x1,-3(x5) with x5=0x104 from MEM
        step(32'h50, JALR_X1);
        step(32'h54, ADDI_X1, 5'd5, 1'b1, 32'h104);
        @(negedge clk);
        chk("jalr_target", jalr_decode, 32'h100);
        chk("jalr_sel", 32'(pc_sel), 32'd3);
        step(32'h100, NOP);
        @(negedge clk);
        chk("jalr_imm4", imm_ex, 32'd4);
        chk("jalr_ctrl", 32'(ctrl_ex), 32'hC0);

        // ADDI x4 then BNE x4,x0,+8: one stall, then taken using the forwarded value
        step(32'h60, ADDI_X4);
        step(32'h64, BNE_X4);
        step(32'h68, NOP);
        @(negedge clk);
        chk("bne_stall", 32'(stall_if), 32'd1);
        chk("bne_sel_during_stall", 32'(pc_sel), 32'd0);
        step(32'h68, NOP, 5'd4, 1'b1, 32'd7);
        @(negedge clk);
        chk("bne_sel", 32'(pc_sel), 32'd1);
        chk("bne_target", br_decode, 32'h6C);
        step(32'h6C, NOP);

        // JAL with PC wrap
        step(32'hFFFF_FFF0, JAL_X1);
        step(32'hFFFF_FFF4, NOP);
        @(negedge clk);
        chk("jal_wrap", jal_decode, 32'h10);
        chk("jal_sel", 32'(pc_sel), 32'd2);
        step(32'h10, NOP);

        // Async reset mid-stream with a load-use stall in flight
        step(32'h80, LW_X2);
        step(32'h84, ADD_X3);
        step(32'h88, NOP);
        #1;
        chk("pre_reset_stall", 32'(stall_if), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl_ex), 32'd0);
        chk("rst_pc_ex", pc_ex, 32'd0);
        chk("rst_rd_ex", 32'(rd_ex), 32'd0);
        chk("rst_stall", 32'(stall_if), 32'd0);
        chk("rst_pc_sel", 32'(pc_sel), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(32'h10, ADDI_X1);
        step(32'h14, NOP);
        step(32'h18, NOP);
        @(negedge clk);
        chk("post_reset_rd", 32'(rd_ex), 32'd1);
        step(32'h1C, NOP);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Sits between fetch and execute. Registers the fetch outputs in an IF/ID register and decodes RV32I.
- Resolves branches, JAL and JALR in decode, and drives the redirect targets, pc_sel, stall_if and flush_if back to fetch.
- Detects load-use and decode-operand hazards. Inserts bubbles into the ID/EX register it owns.

Parameters:
XLEN, 32, datapath/PC width
REG_ADDR_WIDTH, 5, register index width
PC_SEL_WIDTH, 2, pc_sel width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_decode  in  XLEN  PC from fetch
instr_decode  in  XLEN  instruction from fetch (all-zero = bubble)
rs1_addr  out  REG_ADDR_WIDTH  regfile read address 1 (combinational from IF/ID)
rs2_addr  out  REG_ADDR_WIDTH  regfile read address 2
rs1_rdata  in  XLEN  regfile data 1 (write-through regfile)
rs2_rdata  in  XLEN  regfile data 2
mem_rd  in  REG_ADDR_WIDTH  destination of instruction in MEM
mem_reg_write  in  1  MEM instruction writes mem_rd
mem_fwd_data  in  XLEN  MEM-stage result for forwarding
br_decode  out  XLEN  branch target
jal_decode  out  XLEN  JAL target
jalr_decode  out  XLEN  JALR target, bit 0 cleared
pc_sel  out  PC_SEL_WIDTH  0=PC+4, 1=BRANCH, 2=JAL, 3=JALR
stall_if  out  1  hold fetch PC
flush_if  out  1  kill the instruction fetch presents this cycle
pc_ex, rs1_ex, rs2_ex, imm_ex  out  XLEN each  ID/EX register
rd_ex  out  REG_ADDR_WIDTH  ID/EX destination register
ctrl_ex  out  8  {valid, reg_write, mem_read, mem_write, alu_op[3:0]}

Behaviour:
- Reset (async, rst_n=0):
  - IF/ID: pc=0, instr=0.
  - All ID/EX outputs = 0.
  - pc_sel=0, stall_if=0, flush_if=0.
  - Release is synchronous to clk.
- IF/ID register:
  - On clk rise: captures pc_decode/instr_decode unless stall_if=1 (hold).
  - If flush_if=1 it captures instr=0.
  - instr=0 is a bubble: no hazards, no redirect, ID/EX valid=0.
- Decode (combinational from IF/ID):
  - Immediates for I/S/B/U/J are sign-extended to XLEN.
  - br_decode = pc+immB; jal_decode = pc+immJ; jalr_decode = (rs1v+immI) & ~1.
  - All adds are XLEN modulo (wrap, no overflow detect).
- Operand select (rs1v/rs2v):
  - If mem_reg_write and mem_rd!=0 and mem_rd==rsX, use mem_fwd_data; else use rsX_rdata.
  - x0 always reads 0.
- Hazard, stall=1 when the ID instruction is valid and any of:
  - (a) ctrl_ex.valid & mem_read & rd_ex!=0 & rd_ex matches a used rs1/rs2 (load-use);
  - (b) the ID instruction is a branch/JALR and ctrl_ex.valid & reg_write & rd_ex!=0 & rd_ex matches a used source.
- Stall effect: stall_if=1, IF/ID holds, ID/EX loads a bubble (all zeros), pc_sel=0, flush_if=0.
- Redirect, only when stall=0 and the instruction is valid:
  - Taken branch (BEQ/BNE/BLT/BGE/BLTU/BGEU on rs1v/rs2v): pc_sel=1.
  - JAL: pc_sel=2. JALR: pc_sel=3.
  - Each sets flush_if=1. The redirecting instruction still enters ID/EX. Not-taken branch: pc_sel=0.
- ID/EX register: loads the decoded instruction each clk rise. For JAL/JALR, imm_ex=4 and the ALU computes pc+4 for rd.
- Simultaneous stall and redirect condition: stall wins; the redirect is evaluated on the next cycle with fresh operands.
- Unknown opcode: treated as a bubble (valid=0). No redirect.
- Latency: one cycle IF/ID to ID/EX. Branch penalty: one flushed slot.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all ID/EX outputs 0, pc_sel=0, stall_if=0 immediately (async), before any clk edge.
- ADDI x1,x0,5 at pc=0x10 -> next cycle rd_ex=1, imm_ex=5, ctrl_ex valid=1 reg_write=1. No stall.
- LW x2,0(x1) then ADD x3,x2,x2 -> exactly 1 cycle stall_if=1; ID/EX bubble; ADD enters ID/EX on the following cycle.
- BEQ x0,x0,+16 at pc=0x20 -> pc_sel=1, br_decode=0x30, flush_if=1. The next IF/ID instr is 0.
- JALR x1,-3(x5) with x5 forwarded from MEM as 0x104 -> jalr_decode=0x100, pc_sel=3. Also: BNE x4,x0 where rd_ex=4 (ALU op) -> 1 cycle stall, then resolution.
- JAL at pc=0xFFFFFFF0 with imm=+0x20 -> jal_decode=0x00000010 (wrap).
